// File: rtl/cdb_pkg.sv
// -----------------------------------------------------------------------------
// cdb_pkg
// Shared definitions for the common-data-bus (writeback) broadcaster.
//   CDB_TAG_WIDTH  : default destination tag width
//   CDB_DATA_WIDTH : default result data width
//   cdb_entry_t    : one buffered result (tag + data), packed tag-high
// -----------------------------------------------------------------------------
package cdb_pkg;

  localparam int CDB_TAG_WIDTH  = 5;
  localparam int CDB_DATA_WIDTH = 32;

  typedef struct packed {
    logic [CDB_TAG_WIDTH-1:0]  tag;
    logic [CDB_DATA_WIDTH-1:0] data;
  } cdb_entry_t;

endpackage

// File: rtl/cdb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_rr_arbiter
// Purely combinational round-robin arbiter. The search starts at ptr+1
// (modulo NUM_SRC) and moves upward; the first requester found wins.
// Ports:
//   req     in  NUM_SRC     request vector (non-empty FIFOs)
//   ptr     in  IDX_WIDTH   index of the last winner
//   gnt     out NUM_SRC     one-hot grant
//   gnt_idx out IDX_WIDTH   index of the granted source (0 when none)
//   any_gnt out 1           at least one request was granted
// -----------------------------------------------------------------------------
module cdb_rr_arbiter #(
  parameter int NUM_SRC   = 4,
  parameter int IDX_WIDTH = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0]   req,
  input  logic [IDX_WIDTH-1:0] ptr,
  output logic [NUM_SRC-1:0]   gnt,
  output logic [IDX_WIDTH-1:0] gnt_idx,
  output logic                 any_gnt
);

  always_comb begin
    int unsigned          cand;
    logic [IDX_WIDTH-1:0] cand_idx;
    gnt      = '0;
    gnt_idx  = '0;
    any_gnt  = 1'b0;
    cand     = 0;
    cand_idx = '0;
    // Offsets 1..NUM_SRC visit every source once, the last winner last.
    for (int unsigned off = 1; off <= NUM_SRC; off++) begin
      cand     = (32'(ptr) + off) % NUM_SRC;
      cand_idx = cand[IDX_WIDTH-1:0];
      if (!any_gnt && req[cand_idx]) begin
        any_gnt       = 1'b1;
        gnt[cand_idx] = 1'b1;
        gnt_idx       = cand_idx;
      end
    end
  end

endmodule

// File: rtl/cdb_broadcaster.sv
// -----------------------------------------------------------------------------
// cdb_broadcaster
// Writeback (common data bus) transmitter. Each functional unit pushes
// completed results into its own FIFO; a round-robin arbiter pops one
// non-empty FIFO per cycle and the popped entry is broadcast from registers.
// Optional feature: define CDB_FLUSH_EN to add the synchronous flush input.
// Ports:
//   clk        in   1                    rising-edge clock
//   rst_n      in   1                    asynchronous active-low reset
//   src_valid  in   NUM_SRC              per-source result valid
//   src_tag    in   NUM_SRC*TAG_WIDTH    source i at [i*TAG_WIDTH +: TAG_WIDTH]
//   src_data   in   NUM_SRC*DATA_WIDTH   source i at [i*DATA_WIDTH +: DATA_WIDTH]
//   src_ready  out  NUM_SRC              per-source FIFO has space
//   wb_valid   out  1                    registered broadcast valid
//   wb_tag     out  TAG_WIDTH            registered broadcast tag
//   wb_data    out  DATA_WIDTH           registered broadcast data
//   wb_src     out  SRC_IDX_WIDTH        registered source index of broadcast
//   flush      in   1                    (CDB_FLUSH_EN only) discard everything
// -----------------------------------------------------------------------------
module cdb_broadcaster
  import cdb_pkg::*;
#(
  parameter int NUM_SRC       = 4,
  parameter int FIFO_DEPTH    = 2,
  parameter int DATA_WIDTH    = CDB_DATA_WIDTH,
  parameter int TAG_WIDTH     = CDB_TAG_WIDTH,
  parameter int SRC_IDX_WIDTH = $clog2(NUM_SRC)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_SRC-1:0]            src_valid,
  input  logic [NUM_SRC*TAG_WIDTH-1:0]  src_tag,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
  output logic [NUM_SRC-1:0]            src_ready,
  output logic                          wb_valid,
  output logic [TAG_WIDTH-1:0]          wb_tag,
  output logic [DATA_WIDTH-1:0]         wb_data,
  output logic [SRC_IDX_WIDTH-1:0]      wb_src
`ifdef CDB_FLUSH_EN
  ,
  input  logic                          flush
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef struct packed {
    logic [TAG_WIDTH-1:0]  tag;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  logic                     flush_i;
  logic [NUM_SRC-1:0]       req;
  logic [NUM_SRC-1:0]       gnt;
  logic [SRC_IDX_WIDTH-1:0] gnt_idx;
  logic [SRC_IDX_WIDTH-1:0] rr_ptr;
  logic                     any_gnt;
  entry_t                   head [NUM_SRC];
  entry_t                   win;

`ifdef CDB_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Per-source FIFOs
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_fifo
    entry_t           mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;

    // Ready depends on the stored count only; a pop on the same edge does
    // not free the slot early.
    assign src_ready[i] = (count < FULL_CNT);
    assign push         = src_valid[i] & src_ready[i];
    assign pop          = gnt[i];
    assign req[i]       = (count != '0);
    assign head[i]      = mem[rd_ptr];

    always_ff @(posedge clk) begin
      if (push && !flush_i) begin
        mem[wr_ptr] <= '{tag:  src_tag[i*TAG_WIDTH +: TAG_WIDTH],
                         data: src_data[i*DATA_WIDTH +: DATA_WIDTH]};
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else if (flush_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  cdb_rr_arbiter #(
    .NUM_SRC   (NUM_SRC),
    .IDX_WIDTH (SRC_IDX_WIDTH)
  ) u_arb (
    .req     (req),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any_gnt (any_gnt)
  );

  assign win = head[gnt_idx];

  // ---------------------------------------------------------------------------
  // Broadcast registers and round-robin pointer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid <= 1'b0;
      wb_tag   <= '0;
      wb_data  <= '0;
      wb_src   <= '0;
      rr_ptr   <= SRC_IDX_WIDTH'(NUM_SRC - 1);
    end else if (flush_i) begin
      // The pop on a flush edge is swallowed; the pointer is left alone.
      wb_valid <= 1'b0;
    end else if (any_gnt) begin
      wb_valid <= 1'b1;
      wb_tag   <= win.tag;
      wb_data  <= win.data;
      wb_src   <= gnt_idx;
      rr_ptr   <= gnt_idx;
    end else begin
      wb_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cdb_broadcaster.sv
module tb_cdb_broadcaster;

  localparam int NS    = 4;
  localparam int DEPTH = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   src_valid = '0;
  logic [19:0]  src_tag = '0;
  logic [127:0] src_data = '0;
  logic [3:0]   src_ready;
  logic         wb_valid;
  logic [4:0]   wb_tag;
  logic [31:0]  wb_data;
  logic [1:0]   wb_src;
`ifdef CDB_FLUSH_EN
  logic         flush_r = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: one queue per source plus the last-winner index.
  logic [4:0]  mq_tag  [NS][$];
  logic [31:0] mq_data [NS][$];
  int          m_ptr;
  logic        e_valid;
  logic [4:0]  e_tag;
  logic [31:0] e_data;
  logic [1:0]  e_src;
  logic [3:0]  e_rdy;

  always #5 clk = ~clk;

  cdb_broadcaster #(
    .NUM_SRC    (NS),
    .FIFO_DEPTH (DEPTH),
    .DATA_WIDTH (32),
    .TAG_WIDTH  (5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .src_valid (src_valid),
    .src_tag   (src_tag),
    .src_data  (src_data),
    .src_ready (src_ready),
    .wb_valid  (wb_valid),
    .wb_tag    (wb_tag),
    .wb_data   (wb_data),
    .wb_src    (wb_src)
`ifdef CDB_FLUSH_EN
    ,
    .flush     (flush_r)
`endif
  );

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      mq_tag[i].delete();
      mq_data[i].delete();
    end
    m_ptr   = NS - 1;
    e_valid = 1'b0;
    e_tag   = '0;
    e_data  = '0;
    e_src   = '0;
    e_rdy   = 4'hF;
  endtask

  // Drives one cycle of stimulus and advances the model; returns at posedge+1.
  task automatic cycle(input logic [3:0] v, input logic [19:0] t,
                       input logic [127:0] d, input logic fl);
    logic [3:0] acc;
    int         w;
    for (int i = 0; i < NS; i++) acc[i] = v[i] && (mq_tag[i].size() < DEPTH);
    src_valid = v;
    src_tag   = t;
    src_data  = d;
`ifdef CDB_FLUSH_EN
    flush_r   = fl;
`endif
    @(posedge clk);
    #1;
    src_valid = '0;
`ifdef CDB_FLUSH_EN
    flush_r   = 1'b0;
`endif
    w = -1;
    for (int k = 1; k <= NS; k++) begin
      int c;
      c = (m_ptr + k) % NS;
      if (w < 0 && mq_tag[c].size() > 0) w = c;
    end
    if (fl) begin
      for (int i = 0; i < NS; i++) begin
        mq_tag[i].delete();
        mq_data[i].delete();
      end
      e_valid = 1'b0;
    end else begin
      if (w >= 0) begin
        e_valid = 1'b1;
        e_tag   = mq_tag[w].pop_front();
        e_data  = mq_data[w].pop_front();
        e_src   = 2'(w);
        m_ptr   = w;
      end else begin
        e_valid = 1'b0;
      end
      for (int i = 0; i < NS; i++) begin
        if (acc[i]) begin
          mq_tag[i].push_back(t[i*5 +: 5]);
          mq_data[i].push_back(d[i*32 +: 32]);
        end
      end
    end
    for (int i = 0; i < NS; i++) e_rdy[i] = (mq_tag[i].size() < DEPTH);
  endtask

  function automatic logic [127:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 0; c < 10; c++) begin
      cycle('0, '0, '0, 1'b0);
      n_checks++;
      if ({wb_valid, wb_tag, wb_data, wb_src, src_ready} !== {1'b0, 5'd0, 32'd0, 2'd0, 4'hF}) begin
        n_fail++;
        $display("FAIL reset_idle c%0d: got v=%b t=%0d d=%h s=%0d rdy=%b, want all 0, rdy=1111",
                 c, wb_valid, wb_tag, wb_data, wb_src, src_ready);
      end
    end
  endtask

  task automatic test_all_four();
    for (int b = 0; b < 2; b++) begin
      cycle(4'hF, {5'd4, 5'd3, 5'd2, 5'd1}, rnd_data(), 1'b0);
      n_checks++;
      if (wb_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL all4_nobypass b%0d: wb_valid=%b want 0", b, wb_valid);
      end
      for (int k = 0; k < 4; k++) begin
        cycle('0, '0, '0, 1'b0);
        n_checks++;
        if ({wb_valid, wb_tag, wb_data, wb_src, src_ready} !== {e_valid, e_tag, e_data, e_src, e_rdy}
            || wb_src !== 2'(k) || wb_tag !== 5'(k + 1)) begin
          n_fail++;
          $display("FAIL all4_order b%0d k%0d: got v=%b t=%0d d=%h s=%0d rdy=%b want v=1 t=%0d d=%h s=%0d rdy=%b",
                   b, k, wb_valid, wb_tag, wb_data, wb_src, src_ready, k + 1, e_data, k, e_rdy);
        end
      end
    end
  endtask

  task automatic test_single();
    cycle(4'b0001, {15'd0, 5'd3}, {96'd0, 32'hDEADBEEF}, 1'b0);
    n_checks++;
    if (wb_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_lat1: wb_valid=%b want 0", wb_valid);
    end
    cycle('0, '0, '0, 1'b0);
    n_checks++;
    if ({wb_valid, wb_tag, wb_data, wb_src} !== {1'b1, 5'd3, 32'hDEADBEEF, 2'd0}
        || {e_valid, e_tag, e_data, e_src} !== {1'b1, 5'd3, 32'hDEADBEEF, 2'd0}) begin
      n_fail++;
      $display("FAIL single_bcast: got v=%b t=%0d d=%h s=%0d want v=1 t=3 d=deadbeef s=0",
               wb_valid, wb_tag, wb_data, wb_src);
    end
    cycle('0, '0, '0, 1'b0);
    n_checks++;
    if ({wb_valid, wb_tag, wb_data, wb_src} !== {1'b0, 5'd3, 32'hDEADBEEF, 2'd0}) begin
      n_fail++;
      $display("FAIL single_once: got v=%b t=%0d d=%h s=%0d want v=0 (tag/data held)",
               wb_valid, wb_tag, wb_data, wb_src);
    end
  endtask

  task automatic test_stream();
    int         nxt = 10;
    int         miss = 0;
    int         max_miss = 0;
    bit         saw_full = 1'b0;
    logic [4:0] got[$];
    for (int cyc = 0; cyc < 60 && got.size() < 6; cyc++) begin
      logic [3:0]  v;
      logic [19:0] t;
      bit          have2;
      have2 = (mq_tag[2].size() > 0);
      v = 4'b0001;
      t = {5'd0, 5'(nxt), 5'd0, 5'(20 + cyc % 8)};
      if (nxt <= 15) v[2] = 1'b1;
      if (nxt <= 15 && mq_tag[2].size() < DEPTH) nxt++;
      cycle(v, t, rnd_data(), 1'b0);
      n_checks++;
      if ({wb_valid, wb_tag, wb_data, wb_src, src_ready} !== {e_valid, e_tag, e_data, e_src, e_rdy}) begin
        n_fail++;
        $display("FAIL stream c%0d: got v=%b t=%0d d=%h s=%0d rdy=%b want v=%b t=%0d d=%h s=%0d rdy=%b",
                 cyc, wb_valid, wb_tag, wb_data, wb_src, src_ready, e_valid, e_tag, e_data, e_src, e_rdy);
      end
      if (src_ready[2] === 1'b0) saw_full = 1'b1;
      if (wb_valid === 1'b1 && wb_src === 2'd2) begin
        got.push_back(wb_tag);
        miss = 0;
      end else if (have2) begin
        miss++;
      end
      if (miss > max_miss) max_miss = miss;
    end
    for (int c = 0; c < 8; c++) begin
      cycle('0, '0, '0, 1'b0);
      n_checks++;
      if ({wb_valid, wb_tag, wb_data, wb_src, src_ready} !== {e_valid, e_tag, e_data, e_src, e_rdy}) begin
        n_fail++;
        $display("FAIL stream_drain c%0d: got v=%b t=%0d s=%0d want v=%b t=%0d s=%0d",
                 c, wb_valid, wb_tag, wb_src, e_valid, e_tag, e_src);
      end
    end
    n_checks++;
    if (saw_full !== 1'b1) begin
      n_fail++;
      $display("FAIL stream_ready_drop: src_ready[2] low seen=%b want 1", saw_full);
    end
    n_checks++;
    if (max_miss > 1) begin
      n_fail++;
      $display("FAIL stream_fairness: longest src2 wait=%0d want <=1", max_miss);
    end
    n_checks++;
    if (got.size() != 6) begin
      n_fail++;
      $display("FAIL stream_count: got %0d src2 broadcasts want 6", got.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        n_checks++;
        if (got[k] !== 5'(10 + k)) begin
          n_fail++;
          $display("FAIL stream_order k%0d: tag=%0d want %0d", k, got[k], 10 + k);
        end
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] sent[$];
    logic [31:0] got[$];
    for (int j = 0; j < 11; j++) begin
      logic [127:0] d;
      d = rnd_data();
      if (j < 8) begin
        sent.push_back(d[63:32]);
        cycle(4'b0010, {10'd0, 5'(16 + j), 5'd0}, d, 1'b0);
      end else begin
        cycle('0, '0, '0, 1'b0);
      end
      n_checks++;
      if ({wb_valid, wb_tag, wb_data, wb_src, src_ready} !== {e_valid, e_tag, e_data, e_src, e_rdy}) begin
        n_fail++;
        $display("FAIL wrap c%0d: got v=%b t=%0d d=%h s=%0d rdy=%b want v=%b t=%0d d=%h s=%0d rdy=%b",
                 j, wb_valid, wb_tag, wb_data, wb_src, src_ready, e_valid, e_tag, e_data, e_src, e_rdy);
      end
      if (wb_valid === 1'b1 && wb_src === 2'd1) got.push_back(wb_data);
    end
    n_checks++;
    if (got.size() != 8 || got != sent) begin
      n_fail++;
      $display("FAIL wrap_order: got %0d items (first %h) want 8 (first %h)",
               got.size(), (got.size() > 0) ? got[0] : 32'hX, sent[0]);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      logic fl;
`ifdef CDB_FLUSH_EN
      fl = ($urandom_range(0, 19) == 0);
`else
      fl = 1'b0;
`endif
      cycle(4'($urandom), 20'($urandom), rnd_data(), fl);
      n_checks++;
      if ({wb_valid, wb_tag, wb_data, wb_src, src_ready} !== {e_valid, e_tag, e_data, e_src, e_rdy}) begin
        n_fail++;
        $display("FAIL random c%0d: got v=%b t=%0d d=%h s=%0d rdy=%b want v=%b t=%0d d=%h s=%0d rdy=%b",
                 c, wb_valid, wb_tag, wb_data, wb_src, src_ready, e_valid, e_tag, e_data, e_src, e_rdy);
      end
    end
    for (int c = 0; c < 6; c++) cycle('0, '0, '0, 1'b0);
  endtask

  task automatic test_async_reset();
    cycle(4'hF, 20'($urandom), rnd_data(), 1'b0);
    cycle(4'hF, 20'($urandom), rnd_data(), 1'b0);
    n_checks++;
    if (wb_valid !== 1'b1 || e_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset: wb_valid=%b want 1", wb_valid);
    end
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (wb_valid !== 1'b0 || src_ready !== 4'hF) begin
      n_fail++;
      $display("FAIL async_reset: wb_valid=%b rdy=%b want 0 / 1111", wb_valid, src_ready);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 0; c < 4; c++) begin
      cycle('0, '0, '0, 1'b0);
      n_checks++;
      if ({wb_valid, wb_tag, wb_data, wb_src, src_ready} !== {1'b0, 5'd0, 32'd0, 2'd0, 4'hF}) begin
        n_fail++;
        $display("FAIL reset_discard c%0d: got v=%b t=%0d s=%0d rdy=%b want v=0 t=0 s=0 rdy=1111",
                 c, wb_valid, wb_tag, wb_src, src_ready);
      end
    end
  endtask

`ifdef CDB_FLUSH_EN
  task automatic test_flush();
    for (int c = 0; c < 3; c++) cycle(4'hF, {5'd31, 5'd30, 5'd29, 5'd28}, rnd_data(), 1'b0);
    cycle(4'hF, {5'd27, 5'd26, 5'd25, 5'd24}, rnd_data(), 1'b1);
    n_checks++;
    if (wb_valid !== 1'b0 || src_ready !== 4'hF) begin
      n_fail++;
      $display("FAIL flush_edge: wb_valid=%b rdy=%b want 0 / 1111", wb_valid, src_ready);
    end
    for (int c = 0; c < 10; c++) begin
      cycle('0, '0, '0, 1'b0);
      n_checks++;
      if (wb_valid !== 1'b0 || src_ready !== 4'hF || e_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_quiet c%0d: wb_valid=%b tag=%0d rdy=%b want 0 / 1111",
                 c, wb_valid, wb_tag, src_ready);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_all_four();
    test_single();
    test_stream();
    test_wrap();
    test_random();
    test_async_reset();
`ifdef CDB_FLUSH_EN
    test_flush();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/cdb_broadcaster.md
Name: cdb_broadcaster

Overview:
- Transmitter side of the out-of-order core's writeback (common data bus) interface.
- Collects completed results (tag + data) from NUM_SRC functional units and buffers them in per-source FIFOs.
- Arbitrates round-robin among the sources and drives one registered wb_valid/wb_tag/wb_data broadcast per cycle.
- Reservation stations and the ROB consume that broadcast.

Parameters:
- NUM_SRC, 4, number of functional-unit result ports.
- FIFO_DEPTH, 2, entries per source FIFO; power of two, at least 2.
- DATA_WIDTH, 32, result data width.
- TAG_WIDTH, 5, destination tag width.
- SRC_IDX_WIDTH, $clog2(NUM_SRC), width of the source index.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- src_valid  in  NUM_SRC  per-source result valid.
- src_tag  in  NUM_SRC*TAG_WIDTH  per-source destination tag; source i occupies bits [i*TAG_WIDTH +: TAG_WIDTH].
- src_data  in  NUM_SRC*DATA_WIDTH  per-source result; same packing as src_tag.
- src_ready  out  NUM_SRC  per-source FIFO has space.
- wb_valid  out  1  broadcast valid; registered.
- wb_tag  out  TAG_WIDTH  broadcast tag; registered.
- wb_data  out  DATA_WIDTH  broadcast data; registered.
- wb_src  out  SRC_IDX_WIDTH  index of the source that produced the current broadcast; registered.
- flush  in  1  present only with CDB_FLUSH_EN.

Behaviour:
- Reset (async assert, sync deassert by design intent):
  - wb_valid=0, wb_tag=0, wb_data=0, wb_src=0.
  - All FIFOs empty, so src_ready all 1.
  - Round-robin pointer = NUM_SRC-1, so source 0 has highest priority first.
- Reset mid-operation: all buffered results are discarded and wb_valid drops immediately (asynchronously).
- Accept:
  - Source i transfers on an edge where src_valid[i] && src_ready[i]; the entry is written to FIFO i and its count is incremented.
  - src_ready[i] = (count_i < FIFO_DEPTH).
  - src_ready is registered-state only, with no combinational path from arbitration.
  - A full FIFO deasserts ready even if it is popped in the same cycle.
- Arbitration:
  - Combinational over non-empty FIFOs, searching from pointer+1 modulo NUM_SRC upward.
  - The first non-empty FIFO wins and is popped on the edge.
  - wb_valid/tag/data/src load the popped entry, and the pointer updates to the winner index.
  - When no FIFO is non-empty: wb_valid<=0, the pointer holds, and tag/data/src hold their old values.
- No backpressure on the bus: exactly zero or one result is broadcast per cycle.
- Latency:
  - A result accepted on edge E0 can be popped on E1 and is visible on wb_* in the cycle after E1.
  - Minimum latency is 2 clocks from src_valid sampled.
- Simultaneous push and pop on the same FIFO: count is unchanged, both pointers advance, and the data is correct.
- Push into an empty FIFO is not bypassed into the same-edge pop.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally; count is log2(FIFO_DEPTH)+1 bits.
- Order:
  - Strict FIFO order per source.
  - No ordering guarantee across sources.
  - Each non-empty source is served within NUM_SRC cycles (starvation-free).
- Tags are carried opaquely; the same tag may appear twice, with no checking.

Optional Feature:
- Macro: CDB_FLUSH_EN.
- Defined:
  - Adds the flush input.
  - On an edge with flush=1, all FIFO counts and pointers clear and wb_valid<=0.
  - Accepts on that edge are discarded.
  - Any pop on that edge does not broadcast.
  - src_ready returns to all 1 the next cycle.
  - The round-robin pointer is kept.
- Undefined: no flush port; results drain only by broadcast.

Decomposition:
- Package cdb_pkg holds:
  - typedef cdb_entry_t (packed tag + data).
  - Default widths localparams CDB_TAG_WIDTH=5 and CDB_DATA_WIDTH=32.
- Sub-module cdb_rr_arbiter (NUM_SRC):
  - Inputs: req vector and pointer.
  - Outputs: one-hot grant, grant index, any_grant.
  - Purely combinational; instantiated once.
- FIFOs are inline generate loops.

Test Plan:
- Reset then idle:
  - wb_valid=0, src_ready=4'b1111 for 10 cycles.
  - Assert rst_n low with FIFOs holding data: wb_valid falls without a clock edge.
- Single source:
  - src0 sends tag=3 data=0xDEADBEEF for one cycle.
  - wb_valid=1, wb_tag=3, wb_data=0xDEADBEEF, wb_src=0 exactly 2 cycles later, for 1 cycle.
- All 4 sources valid in the same cycle (tags 1,2,3,4):
  - Broadcasts on 4 consecutive cycles with wb_src order 0,1,2,3.
  - A following simultaneous burst with the pointer at 3 is again served as 0,1,2,3.
- Src2 streams tags 10..15 back-to-back while the bus is contended by src0:
  - src_ready[2] drops when 2 entries are held.
  - No tag is lost or reordered.
  - Src2 wins at least every 2nd cycle.
- FIFO wrap: 8 sequential pushes/pops on src1 at full rate; data order is preserved across pointer wrap.
- CDB_FLUSH_EN:
  - Fill all FIFOs, then pulse flush.
  - wb_valid=0 next cycle, and no queued tag is ever broadcast.
  - src_ready=4'b1111 one cycle after flush.
